powerup_spawner: RTL and testbench
==================================

# powerup_spawner

Upstream stage of the power-up timers. Places a single power-up token on the Pong playfield at a pseudo-random position, chooses its type, and detects the ball hitting it. On a hit it emits a one-cycle `eaten` pulse with a stable `mode`, which feed the power-up timer bank and the respawn timer directly. It then waits for the respawn timer's `spawn` pulse before placing the next token.

## Interface
Parameters:
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `MARGIN`, 32: keep-out border on all sides for token placement.
- `PP_SIZE`, 16: token edge length in pixels (square).
- `BALL_SIZE`, 8: ball edge length in pixels (square).
- `LIFETIME`, 600: ticks an uneaten token stays before relocating.
- `LFSR_SEED`, 16'hACE1: LFSR reset value (must be non-zero).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `tick` input 1: one-cycle frame pulse; gates collision checks and lifetime counting.
- `respawn` input 1: one-cycle pulse from the respawn timer's `spawn`.
- `pp_status` input 4: active power-ups from the timer bank (bit n = mode n running).
- `ball_x`, `ball_y` input 10 each: ball top-left pixel.
- `eaten` output 1: one-cycle hit pulse.
- `mode` output 2: token type, valid whenever `pp_visible` or `eaten` is high.
- `pp_x`, `pp_y` output 10 each: token top-left pixel.
- `pp_visible` output 1: token drawn and collidable.

## Operation
- 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, steps every clock in every state, loads `LFSR_SEED` on reset.
- States: PLACE, ACTIVE, EATEN, COOLDOWN. Reset state is PLACE.
- PLACE: candidate x = lfsr[9:0], y = lfsr[15:7] zero-extended to 10 bits.
  - Accept when MARGIN ≤ x ≤ SCREEN_W−MARGIN−PP_SIZE and MARGIN ≤ y ≤ SCREEN_H−MARGIN−PP_SIZE. Otherwise retry next cycle.
  - On accept: latch `pp_x`/`pp_y`, latch `mode`, clear the lifetime counter, go to ACTIVE.
- Mode choice: c = lfsr[1:0]. Take the first of c, c+1, c+2, c+3 (mod 4) whose `pp_status` bit is 0. If all four bits are 1, take c.
- ACTIVE: on each `tick`, evaluate overlap: ball_x+BALL_SIZE > pp_x, ball_x < pp_x+PP_SIZE, ball_y+BALL_SIZE > pp_y, ball_y < pp_y+PP_SIZE. All sums are computed at 11 bits; no wrap.
  - Overlap → EATEN.
  - No overlap → lifetime counter +1. When the counter reaches LIFETIME → PLACE (relocate, no `eaten`).
- EATEN: lasts exactly one cycle, then COOLDOWN.
- COOLDOWN: wait for `respawn`, then go to PLACE.
- `respawn` outside COOLDOWN is ignored. `tick` outside ACTIVE is ignored.
- Overlap and lifetime expiry on the same tick: overlap wins.

## Timing
- Reset values: `eaten` 0, `mode` 0, `pp_x` 0, `pp_y` 0, `pp_visible` 0, lifetime counter 0, LFSR = seed.
- All outputs are registered. `pp_visible` = (state == ACTIVE). `eaten` = (state == EATEN).
- Accept cycle in PLACE → `pp_visible` = 1 on the next cycle.
- Overlapping `tick` in ACTIVE → `eaten` = 1 and `pp_visible` = 0 on the next cycle, for exactly one cycle.
- `mode`, `pp_x`, `pp_y` hold from the PLACE accept until the next PLACE accept, so `mode` is stable during `eaten`.
- `respawn` in COOLDOWN → PLACE on the next cycle. The earliest `pp_visible` is 2 cycles after `respawn`.
- `reset` asserted mid-operation (including during EATEN) forces the reset values immediately. A partially emitted `eaten` is simply cut off.
- Lifetime counter width: $clog2(LIFETIME+1).

## Structure
- Shared package `pong_pkg`: SCREEN_W/SCREEN_H defaults, the state enum (PLACE, ACTIVE, EATEN, COOLDOWN), and the 2-bit mode encoding for the four power-up types.
- One sub-module, `lfsr16`: inputs clk, reset, parameter SEED; output 16-bit state. It is reused by other random placement logic.
- Everything else stays in `powerup_spawner`: mode picker, bounds check, overlap check, FSM.

## Test plan
- Reset with seed 16'hACE1 → all outputs 0. Within 64 cycles after release, `pp_visible` = 1 with 32 ≤ `pp_x` ≤ 592 and 32 ≤ `pp_y` ≤ 432.
- Force the ball onto (`pp_x`+4, `pp_y`+4) and pulse `tick` → `eaten` high for exactly 1 cycle with `mode` equal to the pre-hit value. `pp_visible` drops the same cycle.
- `pp_status` = 4'b1011, repeat 20 placements → `mode` = 2 every time. With `pp_status` = 4'b1111, `mode` equals lfsr[1:0] at the accept cycle.
- Ball far away, 600 ticks → token relocates (new `pp_x`/`pp_y`), `eaten` never asserts.
- In COOLDOWN, 5 `tick`s with the ball on the old position → no `eaten`. A `respawn` pulse given in ACTIVE is ignored. `respawn` in COOLDOWN → `pp_visible` after ≥ 2 cycles.
- Assert `reset` = 0 in the EATEN cycle → `eaten` = 0 immediately. After release, the FSM restarts in PLACE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong constants: playfield size, spawner state encoding, power-up types.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pong_pkg;

  // Default playfield geometry in pixels.
  localparam int PONG_SCREEN_W = 640;
  localparam int PONG_SCREEN_H = 480;

  // Spawner state encoding, kept as plain 2-bit constants for legacy users.
  localparam logic [1:0] PLACE    = 2'd0;
  localparam logic [1:0] ACTIVE   = 2'd1;
  localparam logic [1:0] EATEN    = 2'd2;
  localparam logic [1:0] COOLDOWN = 2'd3;

  // Power-up type encoding; the value doubles as the pp_status bit index.
  typedef enum logic [1:0] {
    PU_WIDE_PADDLE = 2'd0,
    PU_FAST_BALL   = 2'd1,
    PU_MULTI_BALL  = 2'd2,
    PU_SLOW_BALL   = 2'd3
  } pu_mode_e;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, free-running from SEED.
// Latency: new state every clock.
// Backpressure: none, always advances.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  // Shift right; the bit falling out of bit 0 is fed back into the tap positions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/powerup_spawner.sv
// Places one power-up token at a random in-bounds spot, picks its type, detects ball hits.
// Latency: registered outputs; visible 1 cycle after accept, eaten 1 cycle after hitting tick.
// Backpressure: none; respawn only honoured in COOLDOWN, tick only in ACTIVE.
module powerup_spawner
  import pong_pkg::*;
#(
  parameter int          SCREEN_W  = PONG_SCREEN_W,
  parameter int          SCREEN_H  = PONG_SCREEN_H,
  parameter int          MARGIN    = 32,
  parameter int          PP_SIZE   = 16,
  parameter int          BALL_SIZE = 8,
  parameter int          LIFETIME  = 600,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       respawn,
  input  logic [3:0] pp_status,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       eaten,
  output logic [1:0] mode,
  output logic [9:0] pp_x,
  output logic [9:0] pp_y,
  output logic       pp_visible
);

  localparam int LT_W  = $clog2(LIFETIME + 1);
  localparam int X_MIN = MARGIN;
  localparam int X_MAX = SCREEN_W - MARGIN - PP_SIZE;
  localparam int Y_MIN = MARGIN;
  localparam int Y_MAX = SCREEN_H - MARGIN - PP_SIZE;

  logic [15:0]     lfsr;
  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [LT_W-1:0] life_cnt;
  logic [LT_W-1:0] life_nxt;
  logic [9:0]      cand_x;
  logic [9:0]      cand_y;
  logic            accept;
  logic [1:0]      pick;
  logic            overlap;
  logic            expire;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  // Candidate position straight from the LFSR; accept only inside the keep-out border.
  always_comb begin
    cand_x = lfsr[9:0];
    cand_y = {1'b0, lfsr[15:7]};
    accept = ({1'b0, cand_x} >= 11'(X_MIN)) && ({1'b0, cand_x} <= 11'(X_MAX)) &&
             ({1'b0, cand_y} >= 11'(Y_MIN)) && ({1'b0, cand_y} <= 11'(Y_MAX));
  end

  // Mode picker: first type not already running, scanning upward from a random start.
  always_comb begin
    pick = lfsr[1:0];
    for (int i = 3; i >= 0; i--) begin
      if (!pp_status[2'(lfsr[1:0] + 2'(i))]) begin
        pick = 2'(lfsr[1:0] + 2'(i));
      end
    end
  end

  // Axis-aligned box overlap at 11 bits so ball near the right/bottom edge cannot wrap.
  always_comb begin
    overlap = ({1'b0, ball_x} + 11'(BALL_SIZE) > {1'b0, pp_x}) &&
              ({1'b0, ball_x} < {1'b0, pp_x} + 11'(PP_SIZE)) &&
              ({1'b0, ball_y} + 11'(BALL_SIZE) > {1'b0, pp_y}) &&
              ({1'b0, ball_y} < {1'b0, pp_y} + 11'(PP_SIZE));
    life_nxt = life_cnt + LT_W'(1);
    expire   = (life_nxt == LT_W'(LIFETIME));
  end

  // Next-state logic; a hit takes priority over lifetime expiry on the same tick.
  always_comb begin
    state_nxt = state;
    case (state)
      PLACE:    if (accept) state_nxt = ACTIVE;
      ACTIVE: begin
        if (tick) begin
          if (overlap)     state_nxt = EATEN;
          else if (expire) state_nxt = PLACE;
        end
      end
      EATEN:    state_nxt = COOLDOWN;
      COOLDOWN: if (respawn) state_nxt = PLACE;
      default:  state_nxt = PLACE;
    endcase
  end

  // State, latched token attributes, lifetime counter and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PLACE;
      life_cnt   <= '0;
      pp_x       <= '0;
      pp_y       <= '0;
      mode       <= '0;
      eaten      <= 1'b0;
      pp_visible <= 1'b0;
    end else begin
      state      <= state_nxt;
      eaten      <= (state_nxt == EATEN);
      pp_visible <= (state_nxt == ACTIVE);
      if (state == PLACE && accept) begin
        pp_x     <= cand_x;
        pp_y     <= cand_y;
        mode     <= pick;
        life_cnt <= '0;
      end else if (state == ACTIVE && tick && !overlap) begin
        life_cnt <= life_nxt;
      end
    end
  end

endmodule

// File: tb/tb_powerup_spawner.sv
module tb_powerup_spawner;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int X_LO = 32, X_HI = 640 - 32 - 16;
  localparam int Y_LO = 32, Y_HI = 480 - 32 - 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       respawn = 1'b0;
  logic [3:0] pp_status = 4'b0000;
  logic [9:0] ball_x = '0;
  logic [9:0] ball_y = '0;
  logic       eaten;
  logic [1:0] mode;
  logic [9:0] pp_x;
  logic [9:0] pp_y;
  logic       pp_visible;

  int checks = 0;
  int errors = 0;
  int eaten_cnt = 0;

  // Reference expectations for the current token, produced by the model only.
  int cur_x, cur_y, cur_m;
  logic [15:0] m_lfsr;

  powerup_spawner dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .respawn    (respawn),
    .pp_status  (pp_status),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .eaten      (eaten),
    .mode       (mode),
    .pp_x       (pp_x),
    .pp_y       (pp_y),
    .pp_visible (pp_visible)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic bit in_bounds(input logic [15:0] s);
    int x, y;
    x = int'(s[9:0]);
    y = int'(s[15:7]);
    return (x >= X_LO) && (x <= X_HI) && (y >= Y_LO) && (y <= Y_HI);
  endfunction

  function automatic int pick_mode(input int c, input logic [3:0] busy);
    for (int i = 0; i < 4; i++) begin
      if (!busy[(c + i) % 4]) return (c + i) % 4;
    end
    return c;
  endfunction

  // Reference sequence: value held here at a falling edge is what the next rising edge uses.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  always @(negedge clk) begin
    if (eaten === 1'b1) eaten_cnt <= eaten_cnt + 1;
  end

  // Called at a falling edge where the DUT sits in PLACE. Predicts the placement and
  // waits (bounded) for the token; n = falling edges waited, k = predicted retries.
  task automatic place_wait(output int n, output int k);
    logic [15:0] l;
    l = m_lfsr;
    k = 0;
    while (!in_bounds(l) && k < 5000) begin
      l = lfsr_step(l);
      k++;
    end
    cur_x = int'(l[9:0]);
    cur_y = int'(l[15:7]);
    cur_m = pick_mode(int'(l[1:0]), pp_status);
    n = 0;
    while (pp_visible !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drive_hit();
    ball_x = 10'(cur_x + 4);
    ball_y = 10'(cur_y + 4);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic respawn_place(output int n, output int k);
    respawn = 1'b1;
    @(negedge clk);
    respawn = 1'b0;
    place_wait(n, k);
  endtask

  task automatic test_reset();
    int n, k;
    repeat (3) @(negedge clk);
    checks++;
    if ({eaten, mode, pp_x, pp_y, pp_visible} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got eaten=%0b mode=%0d x=%0d y=%0d vis=%0b want all 0",
               eaten, mode, pp_x, pp_y, pp_visible);
    end
    reset = 1'b1;
    place_wait(n, k);
    checks++;
    if (n > 64 || n !== k + 1 || int'(pp_x) != cur_x || int'(pp_y) != cur_y || int'(mode) != cur_m) begin
      errors++;
      $display("FAIL first_place got n=%0d x=%0d y=%0d m=%0d want n=%0d x=%0d y=%0d m=%0d",
               n, pp_x, pp_y, mode, k + 1, cur_x, cur_y, cur_m);
    end
    checks++;
    if (pp_x < 10'(X_LO) || pp_x > 10'(X_HI) || pp_y < 10'(Y_LO) || pp_y > 10'(Y_HI)) begin
      errors++;
      $display("FAIL first_bounds got x=%0d y=%0d want inside [%0d..%0d]x[%0d..%0d]",
               pp_x, pp_y, X_LO, X_HI, Y_LO, Y_HI);
    end
  endtask

  task automatic test_respawn_active();
    respawn = 1'b1;
    @(negedge clk);
    respawn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pp_visible !== 1'b1 || int'(pp_x) != cur_x || int'(pp_y) != cur_y || eaten !== 1'b0) begin
      errors++;
      $display("FAIL respawn_in_active got vis=%0b x=%0d y=%0d eaten=%0b want vis=1 x=%0d y=%0d eaten=0",
               pp_visible, pp_x, pp_y, eaten, cur_x, cur_y);
    end
  endtask

  task automatic test_hit();
    int m0;
    m0 = cur_m;
    drive_hit();
    checks++;
    if (eaten !== 1'b1 || pp_visible !== 1'b0 || int'(mode) != m0) begin
      errors++;
      $display("FAIL hit_pulse got eaten=%0b vis=%0b mode=%0d want eaten=1 vis=0 mode=%0d",
               eaten, pp_visible, mode, m0);
    end
    @(negedge clk);
    checks++;
    if (eaten !== 1'b0 || pp_visible !== 1'b0) begin
      errors++;
      $display("FAIL hit_one_cycle got eaten=%0b vis=%0b want eaten=0 vis=0", eaten, pp_visible);
    end
  endtask

  task automatic test_cooldown();
    int n, k, e0;
    e0 = eaten_cnt;
    ball_x = 10'(cur_x + 4);
    ball_y = 10'(cur_y + 4);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (eaten_cnt != e0 || pp_visible !== 1'b0) begin
      errors++;
      $display("FAIL cooldown_ticks got eaten_pulses=%0d vis=%0b want 0 and 0", eaten_cnt - e0, pp_visible);
    end
    ball_x = '0;
    ball_y = '0;
    respawn_place(n, k);
    checks++;
    if (n !== k + 1 || n < 1 || int'(pp_x) != cur_x || int'(pp_y) != cur_y || int'(mode) != cur_m) begin
      errors++;
      $display("FAIL respawn_place got n=%0d x=%0d y=%0d m=%0d want n=%0d x=%0d y=%0d m=%0d",
               n, pp_x, pp_y, mode, k + 1, cur_x, cur_y, cur_m);
    end
  endtask

  task automatic test_mode_masked();
    int n, k;
    logic [3:0] pats [3];
    pats[0] = 4'b1011;
    pats[1] = 4'b1111;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < (p == 0 ? 20 : 6); i++) begin
        drive_hit();
        @(negedge clk);
        pp_status = (p == 2) ? 4'($urandom_range(0, 15)) : pats[p];
        respawn_place(n, k);
        checks++;
        if (n !== k + 1 || int'(pp_x) != cur_x || int'(pp_y) != cur_y || int'(mode) != cur_m ||
            (p == 0 && mode !== 2'd2)) begin
          errors++;
          $display("FAIL mode_pick st=%b got n=%0d x=%0d y=%0d m=%0d want n=%0d x=%0d y=%0d m=%0d",
                   pp_status, n, pp_x, pp_y, mode, k + 1, cur_x, cur_y, cur_m);
        end
      end
    end
    pp_status = 4'b0000;
  endtask

  task automatic test_lifetime();
    int n, k, e0;
    e0 = eaten_cnt;
    ball_x = '0;
    ball_y = '0;
    tick = 1'b1;
    repeat (599) @(negedge clk);
    checks++;
    if (pp_visible !== 1'b1 || int'(pp_x) != cur_x) begin
      errors++;
      $display("FAIL life_599 got vis=%0b x=%0d want vis=1 x=%0d", pp_visible, pp_x, cur_x);
    end
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (pp_visible !== 1'b0 || eaten !== 1'b0) begin
      errors++;
      $display("FAIL life_600 got vis=%0b eaten=%0b want vis=0 eaten=0", pp_visible, eaten);
    end
    place_wait(n, k);
    checks++;
    if (n !== k + 1 || int'(pp_x) != cur_x || int'(pp_y) != cur_y || int'(mode) != cur_m || eaten_cnt != e0) begin
      errors++;
      $display("FAIL life_relocate got n=%0d x=%0d y=%0d m=%0d pulses=%0d want n=%0d x=%0d y=%0d m=%0d pulses=0",
               n, pp_x, pp_y, mode, eaten_cnt - e0, k + 1, cur_x, cur_y, cur_m);
    end
  endtask

  task automatic test_random_collision();
    int n, k, bx, by;
    bit tk, hit;
    for (int t = 0; t < 40; t++) begin
      bx = cur_x + int'($urandom_range(0, 40)) - 20;
      by = cur_y + int'($urandom_range(0, 40)) - 20;
      tk = ($urandom_range(0, 3) != 0);
      hit = tk && (bx + 8 > cur_x) && (bx < cur_x + 16) && (by + 8 > cur_y) && (by < cur_y + 16);
      ball_x = 10'(bx);
      ball_y = 10'(by);
      tick = tk;
      @(negedge clk);
      tick = 1'b0;
      checks++;
      if (eaten !== hit || pp_visible !== !hit) begin
        errors++;
        $display("FAIL rand_hit t=%0d ball=(%0d,%0d) pp=(%0d,%0d) tick=%0b got eaten=%0b vis=%0b want eaten=%0b",
                 t, bx, by, cur_x, cur_y, tk, eaten, pp_visible, hit);
      end
      if (hit) begin
        @(negedge clk);
        respawn_place(n, k);
        checks++;
        if (n !== k + 1 || int'(pp_x) != cur_x || int'(pp_y) != cur_y || int'(mode) != cur_m) begin
          errors++;
          $display("FAIL rand_replace got n=%0d x=%0d y=%0d m=%0d want n=%0d x=%0d y=%0d m=%0d",
                   n, pp_x, pp_y, mode, k + 1, cur_x, cur_y, cur_m);
        end
      end
    end
  endtask

  task automatic test_reset_in_eaten();
    int n, k;
    drive_hit();
    checks++;
    if (eaten !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_eaten got %0b want 1", eaten);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({eaten, mode, pp_x, pp_y, pp_visible} !== '0) begin
      errors++;
      $display("FAIL reset_in_eaten got eaten=%0b mode=%0d x=%0d y=%0d vis=%0b want all 0",
               eaten, mode, pp_x, pp_y, pp_visible);
    end
    @(negedge clk);
    reset = 1'b1;
    place_wait(n, k);
    checks++;
    if (n !== k + 1 || int'(pp_x) != cur_x || int'(pp_y) != cur_y || int'(mode) != cur_m) begin
      errors++;
      $display("FAIL restart_place got n=%0d x=%0d y=%0d m=%0d want n=%0d x=%0d y=%0d m=%0d",
               n, pp_x, pp_y, mode, k + 1, cur_x, cur_y, cur_m);
    end
  endtask

  initial begin
    test_reset();
    test_respawn_active();
    test_hit();
    test_cooldown();
    test_mode_masked();
    test_lifetime();
    test_random_collision();
    test_reset_in_eaten();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
